// File: rtl/axi_mem_pkg.sv
// Shared types and default widths for the burst memory responder slice.
// State encoding and round-robin marker are used by the top and the bench.
package axi_mem_pkg;

  localparam int DEF_ADDR_W    = 28;
  localparam int DEF_DATA_W    = 256;
  localparam int DEF_LEN_W     = 8;
  localparam int DEF_MEM_DEPTH = 4096;
  localparam int BPB_LOG2      = 5;

  typedef enum logic [1:0] {IDLE, WRITE, READ, RDRAIN} state_e;
  typedef enum logic {RR_READ, RR_WRITE} rr_e;

endpackage

// File: rtl/sram_1rw.sv
// Behavioural single-port SRAM, one access per cycle, read data registered
// so it appears the cycle after the read is issued.
module sram_1rw #(
  parameter int DATA_W = 256,
  parameter int IDX_W  = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**IDX_W];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) rdata_d = mem_q[addr];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (en && we) mem_q[addr] <= wdata;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_burst_mem_responder.sv
// AW/W/AR/R burst slave in front of a single-port SRAM; one burst at a time,
// read/write arbitration alternates when both address channels are valid.
module axi_burst_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] axi_awaddr,
  input  logic [LEN_W-1:0]  axi_awlen,
  input  logic              axi_awvalid,
  output logic              axi_awready,
  input  logic              axi_wvalid,
  output logic              axi_wready,
  input  logic [DATA_W-1:0] axi_wdata,
  input  logic [ADDR_W-1:0] axi_araddr,
  input  logic [LEN_W-1:0]  axi_arlen,
  input  logic              axi_arvalid,
  output logic              axi_arready,
  output logic              axi_rvalid,
  input  logic              axi_rready,
  output logic [DATA_W-1:0] axi_rdata,
  output logic              busy
);

  state_e            state_q, state_d;
  rr_e               rr_q, rr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic [DATA_W-1:0] fifo0_q, fifo0_d, fifo1_q, fifo1_d;
  logic [1:0]        count_q, count_d;
  logic              inflight_q, inflight_d;

  logic              aw_hs, ar_hs, w_hs, pop, push, issue;
  logic              sram_en, sram_we;
  logic [IDX_W-1:0]  sram_addr, aw_idx, ar_idx;
  logic [DATA_W-1:0] sram_rdata;
  logic              unused_addr_bits;

  assign aw_idx = axi_awaddr[BPB_LOG2 +: IDX_W];
  assign ar_idx = axi_araddr[BPB_LOG2 +: IDX_W];
  assign unused_addr_bits = ^{axi_awaddr[BPB_LOG2-1:0], axi_awaddr[ADDR_W-1:BPB_LOG2+IDX_W],
                              axi_araddr[BPB_LOG2-1:0], axi_araddr[ADDR_W-1:BPB_LOG2+IDX_W]};

  assign aw_hs = axi_awvalid && axi_awready;
  assign ar_hs = axi_arvalid && axi_arready;
  assign w_hs  = axi_wvalid && axi_wready;
  assign push  = inflight_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      rr_q       <= RR_READ;
      idx_q      <= '0;
      beats_q    <= '0;
      fifo0_q    <= '0;
      fifo1_q    <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      idx_q      <= idx_d;
      beats_q    <= beats_d;
      fifo0_q    <= fifo0_d;
      fifo1_q    <= fifo1_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
    end
  end

  // In READ, beats_q counts addresses still to issue; the AR handshake issues the first.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    idx_d      = idx_q;
    beats_d    = beats_q;
    fifo0_d    = fifo0_q;
    fifo1_d    = fifo1_q;
    count_d    = count_q;
    inflight_d = issue;

    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) fifo0_d = sram_rdata;
        else                 fifo1_d = sram_rdata;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        fifo0_d = fifo1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          fifo0_d = sram_rdata;
        end else begin
          fifo0_d = fifo1_q;
          fifo1_d = sram_rdata;
        end
      end
      default: ;
    endcase

    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          state_d = WRITE;
          idx_d   = aw_idx;
          beats_d = axi_awlen;
          rr_d    = RR_WRITE;
        end else if (ar_hs) begin
          state_d = (axi_arlen == '0) ? RDRAIN : READ;
          idx_d   = ar_idx + IDX_W'(1);
          beats_d = axi_arlen;
          rr_d    = RR_READ;
        end
      end
      WRITE: begin
        if (w_hs) begin
          idx_d   = idx_q + IDX_W'(1);
          beats_d = beats_q - LEN_W'(1);
          if (beats_q == '0) state_d = IDLE;
        end
      end
      READ: begin
        if (issue) begin
          idx_d   = idx_q + IDX_W'(1);
          beats_d = beats_q - LEN_W'(1);
          if (beats_q == LEN_W'(1)) state_d = RDRAIN;
        end
      end
      RDRAIN: begin
        if (count_d == 2'd0 && !inflight_d) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop in the same cycle frees a FIFO slot, keeping full-rate streaming.
  always_comb begin
    axi_awready = 1'b0;
    axi_arready = 1'b0;
    axi_wready  = 1'b0;
    issue       = 1'b0;
    sram_addr   = idx_q;
    busy        = (state_q != IDLE);
    axi_rvalid  = (count_q != 2'd0);
    axi_rdata   = fifo0_q;
    pop         = axi_rvalid && axi_rready;

    case (state_q)
      IDLE: begin
        axi_awready = axi_awvalid && (!axi_arvalid || rr_q == RR_READ);
        axi_arready = axi_arvalid && (!axi_awvalid || rr_q == RR_WRITE);
        if (axi_arready) begin
          issue     = 1'b1;
          sram_addr = ar_idx;
        end
      end
      WRITE: axi_wready = 1'b1;
      READ:  issue = ((count_q + {1'b0, inflight_q}) < 2'd2) || pop;
      default: ;
    endcase

    sram_we = axi_wvalid && axi_wready;
    sram_en = issue || sram_we;
  end

  sram_1rw #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_sram (
    .clk   (clk),
    .en    (sram_en),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (axi_wdata),
    .rdata (sram_rdata)
  );

endmodule
